// File: rtl/cache_pkg.sv
// Shared types and default geometry for the two-way set-associative cache controller.
package cache_pkg;

  localparam int SETS  = 16;
  localparam int TAG_W = 23;
  localparam int SET_W = $clog2(SETS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMPARE   = 2'd1,
    WRITEBACK = 2'd2,
    REFILL    = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/cache_ctrl_victim_sel.sv
// Replacement policy for a two-way set: picks the way to evict and the lru value
// to store once a way has been used.
module victim_sel (
  input  logic [1:0] valid_i,
  input  logic       lru_i,
  input  logic       upd_way_i,
  output logic       victim_o,
  output logic       lru_upd_o
);

  always_comb begin
    // An empty way is always filled before anything valid is evicted.
    if (!valid_i[0]) begin
      victim_o = 1'b0;
    end else if (!valid_i[1]) begin
      victim_o = 1'b1;
    end else begin
      victim_o = lru_i;
    end
    lru_upd_o = ~upd_way_i;
  end

endmodule

// File: rtl/cache_ctrl.sv
// Two-way set-associative cache controller: tag compare, dirty writeback and refill
// sequencing against an external tag/data array and a single memory port.
//
// state     | meaning
// IDLE      | ready for a request; issues the array read on acceptance
// COMPARE   | tags back from the array; hit completes, miss picks a victim
// WRITEBACK | dirty victim being written to memory
// REFILL    | requested line being fetched; completes on memory ack
module cache_ctrl #(
  parameter int SETS  = 16,
  parameter int TAG_W = 23,
  localparam int SET_W = $clog2(SETS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [SET_W-1:0]      req_set_i,
  input  logic [TAG_W-1:0]      req_tag_i,
  output logic                  req_ready_o,
  output logic                  resp_valid_o,
  output logic                  resp_way_o,
  output logic                  array_re_o,
  output logic [SET_W-1:0]      array_set_o,
  output logic [1:0]            array_we_o,
  input  logic [1:0][TAG_W-1:0] tag_rdata_i,
  output logic                  mem_req_o,
  output logic                  mem_write_o,
  output logic [SET_W-1:0]      mem_set_o,
  output logic [TAG_W-1:0]      mem_tag_o,
  input  logic                  mem_ready_i
);

  import cache_pkg::*;

  ctrl_state_t state_q, state_d;

  logic [SET_W-1:0] set_q, set_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             write_q, write_d;
  logic             victim_q, victim_d;
  logic [TAG_W-1:0] victim_tag_q, victim_tag_d;

  logic [SETS-1:0][1:0] valid_q, valid_d;
  logic [SETS-1:0][1:0] dirty_q, dirty_d;
  logic [SETS-1:0]      lru_q, lru_d;

  logic [1:0] way_match;
  logic       hit;
  logic       hit_way;
  logic       upd_way;
  logic       victim;
  logic       lru_upd;

  // Way 0 has priority when both ways report the same tag.
  assign way_match[0] = valid_q[set_q][0] && (tag_rdata_i[0] == tag_q);
  assign way_match[1] = valid_q[set_q][1] && (tag_rdata_i[1] == tag_q);
  assign hit          = |way_match;
  assign hit_way      = ~way_match[0];
  assign upd_way      = (state_q == REFILL) ? victim_q : hit_way;

  victim_sel u_victim_sel (
    .valid_i   (valid_q[set_q]),
    .lru_i     (lru_q[set_q]),
    .upd_way_i (upd_way),
    .victim_o  (victim),
    .lru_upd_o (lru_upd)
  );

  always_comb begin
    state_d      = state_q;
    set_d        = set_q;
    tag_d        = tag_q;
    write_d      = write_q;
    victim_d     = victim_q;
    victim_tag_d = victim_tag_q;
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    lru_d        = lru_q;

    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_way_o   = 1'b0;
    array_re_o   = 1'b0;
    array_set_o  = '0;
    array_we_o   = 2'b00;
    mem_req_o    = 1'b0;
    mem_write_o  = 1'b0;
    mem_set_o    = '0;
    mem_tag_o    = '0;

    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          set_d       = req_set_i;
          tag_d       = req_tag_i;
          write_d     = req_write_i;
          array_re_o  = 1'b1;
          array_set_o = req_set_i;
          state_d     = COMPARE;
        end
      end

      COMPARE: begin
        array_set_o = set_q;
        if (hit) begin
          resp_valid_o = 1'b1;
          resp_way_o   = hit_way;
          lru_d[set_q] = lru_upd;
          if (write_q) begin
            array_we_o[hit_way]     = 1'b1;
            dirty_d[set_q][hit_way] = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d     = victim;
          victim_tag_d = tag_rdata_i[victim];
          // Only a line that is both valid and dirty needs to go back to memory.
          if (valid_q[set_q][victim] && dirty_q[set_q][victim]) begin
            state_d = WRITEBACK;
          end else begin
            state_d = REFILL;
          end
        end
      end

      WRITEBACK: begin
        array_set_o = set_q;
        mem_req_o   = 1'b1;
        mem_write_o = 1'b1;
        mem_set_o   = set_q;
        mem_tag_o   = victim_tag_q;
        if (mem_ready_i) begin
          state_d = REFILL;
        end
      end

      REFILL: begin
        array_set_o = set_q;
        mem_req_o   = 1'b1;
        mem_set_o   = set_q;
        mem_tag_o   = tag_q;
        if (mem_ready_i) begin
          array_we_o[victim_q]     = 1'b1;
          valid_d[set_q][victim_q] = 1'b1;
          dirty_d[set_q][victim_q] = write_q;
          lru_d[set_q]             = lru_upd;
          resp_valid_o             = 1'b1;
          resp_way_o               = victim_q;
          state_d                  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      set_q        <= '0;
      tag_q        <= '0;
      write_q      <= 1'b0;
      victim_q     <= 1'b0;
      victim_tag_q <= '0;
      valid_q      <= '0;
      dirty_q      <= '0;
      lru_q        <= '0;
    end else begin
      state_q      <= state_d;
      set_q        <= set_d;
      tag_q        <= tag_d;
      write_q      <= write_d;
      victim_q     <= victim_d;
      victim_tag_q <= victim_tag_d;
      valid_q      <= valid_d;
      dirty_q      <= dirty_d;
      lru_q        <= lru_d;
    end
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: plays the tag array and memory, and predicts every
// response from a per-set cache model (tags, valid, dirty, eviction pointer).
module tb_cache_ctrl;

  localparam int SETS  = 16;
  localparam int TAG_W = 23;
  localparam int SET_W = $clog2(SETS);

  logic                  clk = 1'b0;
  logic                  rst_ni = 1'b0;
  logic                  req_valid = 1'b0;
  logic                  req_write = 1'b0;
  logic [SET_W-1:0]      req_set = '0;
  logic [TAG_W-1:0]      req_tag = '0;
  logic                  req_ready;
  logic                  resp_valid;
  logic                  resp_way;
  logic                  array_re;
  logic [SET_W-1:0]      array_set;
  logic [1:0]            array_we;
  logic [1:0][TAG_W-1:0] tag_rdata = '0;
  logic                  mem_req;
  logic                  mem_write;
  logic [SET_W-1:0]      mem_set;
  logic [TAG_W-1:0]      mem_tag;
  logic                  mem_ready = 1'b0;

  cache_ctrl #(.SETS(SETS), .TAG_W(TAG_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_write_i  (req_write),
    .req_set_i    (req_set),
    .req_tag_i    (req_tag),
    .req_ready_o  (req_ready),
    .resp_valid_o (resp_valid),
    .resp_way_o   (resp_way),
    .array_re_o   (array_re),
    .array_set_o  (array_set),
    .array_we_o   (array_we),
    .tag_rdata_i  (tag_rdata),
    .mem_req_o    (mem_req),
    .mem_write_o  (mem_write),
    .mem_set_o    (mem_set),
    .mem_tag_o    (mem_tag),
    .mem_ready_i  (mem_ready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference cache contents.
  bit               mv   [SETS][2];
  bit               md   [SETS][2];
  logic [TAG_W-1:0] mt   [SETS][2];
  bit               mlru [SETS];

  int resp_cnt = 0;
  int exp_resp = 0;
  bit prev_resp = 1'b0;
  bit consec = 1'b0;

  always @(posedge clk) begin
    if (resp_valid && prev_resp) consec <= 1'b1;
    prev_resp <= resp_valid;
    if (resp_valid) resp_cnt <= resp_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        mv[s][w] = 1'b0;
        md[s][w] = 1'b0;
        mt[s][w] = '0;
      end
      mlru[s] = 1'b0;
    end
  endfunction

  task automatic check_quiet(input string pfx);
    chk({pfx, "_ready"}, req_ready, 1);
    chk({pfx, "_resp"}, resp_valid, 0);
    chk({pfx, "_rway"}, resp_way, 0);
    chk({pfx, "_re"}, array_re, 0);
    chk({pfx, "_aset"}, array_set, 0);
    chk({pfx, "_we"}, array_we, 0);
    chk({pfx, "_mreq"}, mem_req, 0);
    chk({pfx, "_mwr"}, mem_write, 0);
    chk({pfx, "_mset"}, mem_set, 0);
    chk({pfx, "_mtag"}, mem_tag, 0);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    req_valid = 1'b0;
    req_set   = '0;
    mem_ready = 1'(($urandom % 2));
    #1;
    check_quiet("idle");
  endtask

  // One request end to end. rdly < 0 picks a random refill latency; abort
  // pulls reset during the first refill cycle instead of acknowledging.
  task automatic do_req(input bit w, input int s, input logic [TAG_W-1:0] t,
                        input int rdly, input bit abort, input bit hold);
    bit hit;
    int hw;
    int v;
    int d;
    hit = 1'b0;
    hw  = 0;

    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_set   = SET_W'(s);
    req_tag   = t;
    mem_ready = 1'(($urandom % 2));
    tag_rdata[0] = TAG_W'($urandom);
    tag_rdata[1] = TAG_W'($urandom);
    #1;
    chk("acc_ready", req_ready, 1);
    chk("acc_re", array_re, 1);
    chk("acc_aset", array_set, s);
    chk("acc_resp", resp_valid, 0);
    chk("acc_mreq", mem_req, 0);

    if (mv[s][0] && mt[s][0] == t) begin
      hit = 1'b1;
      hw  = 0;
    end else if (mv[s][1] && mt[s][1] == t) begin
      hit = 1'b1;
      hw  = 1;
    end

    @(negedge clk);
    req_valid = hold ? 1'b1 : 1'(($urandom % 2));
    req_write = 1'(($urandom % 2));
    req_set   = SET_W'($urandom);
    req_tag   = TAG_W'($urandom);
    mem_ready = 1'(($urandom % 2));
    // Invalid ways sometimes carry a matching stale tag; it must not hit.
    for (int i = 0; i < 2; i++) begin
      if (mv[s][i]) tag_rdata[i] = mt[s][i];
      else tag_rdata[i] = ($urandom % 2) ? t : TAG_W'($urandom);
    end
    #1;
    chk("cmp_ready", req_ready, 0);
    chk("cmp_aset", array_set, s);
    chk("cmp_re", array_re, 0);
    chk("cmp_mreq", mem_req, 0);

    if (hit) begin
      chk("hit_resp", resp_valid, 1);
      chk("hit_way", resp_way, hw);
      chk("hit_we", array_we, w ? (2'b01 << hw) : 2'b00);
      mlru[s] = (hw == 0);
      if (w) md[s][hw] = 1'b1;
      exp_resp++;
      return;
    end

    chk("miss_resp", resp_valid, 0);
    chk("miss_we", array_we, 0);

    if (!mv[s][0]) v = 0;
    else if (!mv[s][1]) v = 1;
    else v = int'(mlru[s]);

    if (mv[s][v] && md[s][v]) begin
      d = $urandom_range(0, 3);
      for (int i = 0; i <= d; i++) begin
        @(negedge clk);
        mem_ready = (i == d);
        req_valid = 1'(($urandom % 2));
        #1;
        chk("wb_mreq", mem_req, 1);
        chk("wb_mwr", mem_write, 1);
        chk("wb_mtag", mem_tag, mt[s][v]);
        chk("wb_mset", mem_set, s);
        chk("wb_resp", resp_valid, 0);
        chk("wb_we", array_we, 0);
        chk("wb_ready", req_ready, 0);
      end
    end

    d = (rdly < 0) ? $urandom_range(0, 4) : rdly;
    for (int i = 0; i <= d; i++) begin
      @(negedge clk);
      mem_ready = (i == d) && !abort;
      req_valid = 1'(($urandom % 2));
      #1;
      chk("rf_mreq", mem_req, 1);
      chk("rf_mwr", mem_write, 0);
      chk("rf_mtag", mem_tag, t);
      chk("rf_mset", mem_set, s);
      chk("rf_ready", req_ready, 0);
      if (abort) begin
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni    = 1'b1;
        req_valid = 1'b0;
        req_set   = '0;
        mem_ready = 1'b0;
        #1;
        check_quiet("rst");
        model_reset();
        return;
      end
      if (i == d) begin
        chk("rf_resp", resp_valid, 1);
        chk("rf_way", resp_way, v);
        chk("rf_we", array_we, 2'b01 << v);
      end else begin
        chk("rf_wait_resp", resp_valid, 0);
        chk("rf_wait_we", array_we, 0);
      end
    end
    mv[s][v]  = 1'b1;
    md[s][v]  = w;
    mt[s][v]  = t;
    mlru[s]   = (v == 0);
    exp_resp++;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    #1;
    check_quiet("por");

    do_req(1'b0, 3, 23'h10, 4, 1'b0, 1'b0);  // cold miss, way 0
    do_req(1'b0, 3, 23'h10, -1, 1'b0, 1'b0); // hit way 0
    do_req(1'b0, 3, 23'h20, -1, 1'b0, 1'b0); // fills way 1
    do_req(1'b1, 3, 23'h20, -1, 1'b0, 1'b0); // store hit way 1
    do_req(1'b0, 3, 23'h30, -1, 1'b0, 1'b0); // clean eviction of way 0
    do_req(1'b0, 3, 23'h40, -1, 1'b0, 1'b0); // dirty eviction of way 1
    do_req(1'b0, 3, 23'h50, 3, 1'b1, 1'b0);  // reset mid-refill
    do_req(1'b0, 3, 23'h30, -1, 1'b0, 1'b0); // misses after reset
    for (int i = 0; i < 3; i++) do_req(1'b0, 3, 23'h30, -1, 1'b0, 1'b1);
    idle_cycle();

    for (int n = 0; n < 300; n++) begin
      do_req(1'(($urandom % 2)), int'($urandom % 4), TAG_W'($urandom % 6), -1,
             ($urandom % 40) == 0, 1'(($urandom % 3) == 0));
      if ($urandom % 5 == 0) idle_cycle();
    end
    idle_cycle();
    @(negedge clk);

    chk("resp_count", resp_cnt, exp_resp);
    chk("resp_consec", consec, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running expected finished");
    $fatal(1);
  end

endmodule
